// File: rtl/ysyx_bus_scheduler.sv
// Arbitrates one single-beat AXI4 master port between IFU fetches and LSU loads/stores,
// with a starvation guard for the IFU, 32->64-bit lane steering and sticky error capture.
module ysyx_bus_scheduler #(
    parameter int ADDR_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_rvalid_o,
    input  logic              lsu_req,
    input  logic              lsu_we,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [3:0]        lsu_strb,
    input  logic [31:0]       lsu_wdata,
    output logic              lsu_rvalid_o,
    output logic              lsu_bvalid_o,
    output logic [31:0]       rdata_o,
    output logic              err_o,
    output logic [ADDR_W-1:0] io_master_araddr,
    output logic [2:0]        io_master_arsize,
    output logic              io_master_arvalid,
    input  logic              io_master_arready,
    input  logic [63:0]       io_master_rdata,
    input  logic [1:0]        io_master_rresp,
    input  logic              io_master_rvalid,
    output logic [ADDR_W-1:0] io_master_awaddr,
    output logic [2:0]        io_master_awsize,
    output logic              io_master_awvalid,
    input  logic              io_master_awready,
    output logic [63:0]       io_master_wdata,
    output logic [7:0]        io_master_wstrb,
    output logic              io_master_wvalid,
    input  logic              io_master_wready,
    input  logic [1:0]        io_master_bresp,
    input  logic              io_master_bvalid
);
    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_B, S_RESP} state_t;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t            r_state;
    logic [3:0]        r_starve;
    logic              r_is_ifu;
    logic              r_hi;
    logic              r_ifu_rvalid, r_lsu_rvalid, r_lsu_bvalid, r_err;
    logic [31:0]       r_rdata;
    logic [ADDR_W-1:0] r_araddr, r_awaddr;
    logic [2:0]        r_arsize, r_awsize;
    logic              r_arvalid, r_awvalid, r_wvalid;
    logic [63:0]       r_wdata;
    logic [7:0]        r_wstrb;

    logic              w_grant_lsu, w_grant_ifu, w_we, w_misalign;
    logic [ADDR_W-1:0] w_addr;
    logic [3:0]        w_strb;
    logic [1:0]        w_off;
    logic [7:0]        w_mask;
    logic [2:0]        w_size;
    logic [31:0]       w_wword;

    // LSU wins unless the IFU has already been passed over STARVE_MAX times in a row
    assign w_grant_lsu = lsu_req && !(ifu_req && (r_starve == STARVE_LIM));
    assign w_grant_ifu = ifu_req && !w_grant_lsu;
    assign w_addr      = w_grant_lsu ? lsu_addr : ifu_addr;
    assign w_strb      = w_grant_lsu ? lsu_strb : 4'hF;
    assign w_we        = w_grant_lsu && lsu_we;
    assign w_off       = w_addr[1:0];
    assign w_mask      = {4'b0000, w_strb} << w_off;
    assign w_misalign  = |w_mask[7:4];
    assign w_size      = (w_strb == 4'h1) ? 3'd0 : (w_strb == 4'h3) ? 3'd1 : 3'd2;
    assign w_wword     = lsu_wdata << {w_off, 3'b000};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_starve     <= 4'd0;
            r_is_ifu     <= 1'b0;
            r_hi         <= 1'b0;
            r_ifu_rvalid <= 1'b0;
            r_lsu_rvalid <= 1'b0;
            r_lsu_bvalid <= 1'b0;
            r_err        <= 1'b0;
            r_rdata      <= 32'd0;
            r_araddr     <= '0;
            r_awaddr     <= '0;
            r_arsize     <= 3'd0;
            r_awsize     <= 3'd0;
            r_arvalid    <= 1'b0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_wdata      <= 64'd0;
            r_wstrb      <= 8'd0;
        end else begin
            r_ifu_rvalid <= 1'b0;
            r_lsu_rvalid <= 1'b0;
            r_lsu_bvalid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_lsu || w_grant_ifu) begin
                        r_is_ifu <= w_grant_ifu;
                        r_hi     <= w_addr[2];
                        if (w_grant_ifu)
                            r_starve <= 4'd0;
                        else if (ifu_req && r_starve != STARVE_LIM)
                            r_starve <= r_starve + 4'd1;
                        if (w_misalign) begin
                            // Access would straddle the word: answer locally, never touch the bus
                            r_err   <= 1'b1;
                            r_rdata <= 32'd0;
                            r_state <= S_RESP;
                            if (w_grant_ifu)  r_ifu_rvalid <= 1'b1;
                            else if (w_we)    r_lsu_bvalid <= 1'b1;
                            else              r_lsu_rvalid <= 1'b1;
                        end else if (w_we) begin
                            r_awaddr  <= w_addr;
                            r_awsize  <= w_size;
                            r_wdata   <= {w_wword, w_wword};
                            r_wstrb   <= w_addr[2] ? {w_mask[3:0], 4'b0000} : {4'b0000, w_mask[3:0]};
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= S_AW;
                        end else begin
                            r_araddr  <= w_addr;
                            r_arsize  <= w_size;
                            r_arvalid <= 1'b1;
                            r_state   <= S_AR;
                        end
                    end
                end
                S_AR: begin
                    if (io_master_arready) begin
                        r_arvalid <= 1'b0;
                        r_state   <= S_R;
                    end
                end
                S_R: begin
                    if (io_master_rvalid) begin
                        r_rdata <= r_hi ? io_master_rdata[63:32] : io_master_rdata[31:0];
                        if (io_master_rresp != 2'b00) r_err <= 1'b1;
                        if (r_is_ifu) r_ifu_rvalid <= 1'b1;
                        else          r_lsu_rvalid <= 1'b1;
                        r_state <= S_RESP;
                    end
                end
                S_AW: begin
                    if (io_master_awready) r_awvalid <= 1'b0;
                    if (io_master_wready)  r_wvalid  <= 1'b0;
                    if ((!r_awvalid || io_master_awready) && (!r_wvalid || io_master_wready))
                        r_state <= S_B;
                end
                S_B: begin
                    if (io_master_bvalid) begin
                        if (io_master_bresp != 2'b00) r_err <= 1'b1;
                        r_lsu_bvalid <= 1'b1;
                        r_state      <= S_RESP;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ifu_rvalid_o      = r_ifu_rvalid;
    assign lsu_rvalid_o      = r_lsu_rvalid;
    assign lsu_bvalid_o      = r_lsu_bvalid;
    assign rdata_o           = r_rdata;
    assign err_o             = r_err;
    assign io_master_araddr  = r_araddr;
    assign io_master_arsize  = r_arsize;
    assign io_master_arvalid = r_arvalid;
    assign io_master_awaddr  = r_awaddr;
    assign io_master_awsize  = r_awsize;
    assign io_master_awvalid = r_awvalid;
    assign io_master_wdata   = r_wdata;
    assign io_master_wstrb   = r_wstrb;
    assign io_master_wvalid  = r_wvalid;
endmodule

// File: tb/tb_ysyx_bus_scheduler.sv
// Bench for ysyx_bus_scheduler: transaction-timeline model of requesters and an AXI slave,
// compared against the DUT every cycle, plus directed scenarios with literal expectations.
module tb_ysyx_bus_scheduler;
    localparam int SMAX = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req, lsu_req, lsu_we;
    logic [31:0] ifu_addr, lsu_addr, lsu_wdata;
    logic [3:0]  lsu_strb;
    logic        ifu_rvalid_o, lsu_rvalid_o, lsu_bvalid_o, err_o;
    logic [31:0] rdata_o;
    logic [31:0] araddr, awaddr;
    logic [2:0]  arsize, awsize;
    logic        arvalid, arready, rvalid, awvalid, awready, wvalid, wready, bvalid;
    logic [63:0] rdata, wdata;
    logic [1:0]  rresp, bresp;
    logic [7:0]  wstrb;

    always #5 clk = ~clk;

    ysyx_bus_scheduler #(.ADDR_W(32), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_rvalid_o(ifu_rvalid_o),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_strb(lsu_strb),
        .lsu_wdata(lsu_wdata), .lsu_rvalid_o(lsu_rvalid_o), .lsu_bvalid_o(lsu_bvalid_o),
        .rdata_o(rdata_o), .err_o(err_o),
        .io_master_araddr(araddr), .io_master_arsize(arsize), .io_master_arvalid(arvalid),
        .io_master_arready(arready), .io_master_rdata(rdata), .io_master_rresp(rresp),
        .io_master_rvalid(rvalid), .io_master_awaddr(awaddr), .io_master_awsize(awsize),
        .io_master_awvalid(awvalid), .io_master_awready(awready), .io_master_wdata(wdata),
        .io_master_wstrb(wstrb), .io_master_wvalid(wvalid), .io_master_wready(wready),
        .io_master_bresp(bresp), .io_master_bvalid(bvalid)
    );

    int n_tests = 0, n_fail = 0;
    int cyc = 0;

    // requesters
    bit          ifu_pend, lsu_pend, lsu_w, gen_en, hold, rst_next;
    logic [31:0] ifu_a, lsu_a, lsu_wd;
    logic [3:0]  lsu_s;

    // in-flight transaction, expressed as a timeline of cycle numbers
    bit          busy, x_ifu, x_we, x_err, x_seterr, m_err;
    int          t_start, t_ahs, t_whs, t_data, t_pulse, t_free;
    int          starve;
    logic [31:0] x_addr, x_rexp;
    logic [2:0]  x_size;
    logic [7:0]  x_wstrb;
    logic [63:0] x_wdata, s_rdata;
    logic [1:0]  s_resp;

    // fixed slave behaviour for directed scenarios
    bit          fx_en;
    int          fx_da, fx_dw, fx_dr, fx_db;
    logic [63:0] fx_rdata;
    logic [1:0]  fx_resp;

    // DUT observations
    int          n_ip, n_lr, n_lb, n_arv;
    int          dut_log[$];
    logic [31:0] last_rdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    task automatic grant();
        bit g_lsu;
        logic [3:0]  strb;
        logic [31:0] w;
        int off, mask, da, dw, dr, db;
        g_lsu = lsu_pend && !(ifu_pend && starve == SMAX);
        if (!g_lsu) starve = 0;
        else if (ifu_pend && starve < SMAX) starve++;
        x_ifu  = !g_lsu;
        x_addr = g_lsu ? lsu_a : ifu_a;
        strb   = g_lsu ? lsu_s : 4'hF;
        x_we   = g_lsu && lsu_w;
        off    = int'(x_addr % 4);
        mask   = int'(strb) << off;
        x_err  = mask > 15;
        x_size = (strb == 4'h1) ? 3'd0 : (strb == 4'h3) ? 3'd1 : 3'd2;
        x_wstrb = x_addr[2] ? 8'(mask * 16) : 8'(mask);
        w = lsu_wd << (8 * off);
        x_wdata = {w, w};
        if (fx_en) begin
            da = fx_da; dw = fx_dw; dr = fx_dr; db = fx_db; s_rdata = fx_rdata; s_resp = fx_resp;
        end else begin
            da = $urandom % 4; dw = $urandom % 4; dr = $urandom % 4; db = $urandom % 4;
            s_rdata = {$urandom, $urandom};
            s_resp  = ($urandom % 8 == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        end
        x_rexp   = x_err ? 32'd0 : (x_addr[2] ? s_rdata[63:32] : s_rdata[31:0]);
        x_seterr = x_err || (s_resp != 2'b00);
        t_start  = cyc + 1;
        if (x_err) t_pulse = cyc + 1;
        else if (x_we) begin
            t_ahs = t_start + da;
            t_whs = t_start + dw;
            t_data = ((t_ahs > t_whs) ? t_ahs : t_whs) + 1 + db;
            t_pulse = t_data + 1;
        end else begin
            t_ahs = t_start + da;
            t_data = t_ahs + 1 + dr;
            t_pulse = t_data + 1;
        end
        t_free = t_pulse + 1;
        busy = 1;
    endtask

    // one clock cycle: check the DUT's outputs for this cycle, then drive this cycle's inputs
    task automatic step();
        logic rd, wr, e_arv, e_awv, e_wv, e_ip, e_lr, e_lb;
        int r;
        @(negedge clk);
        cyc++;
        rd = busy && !x_we && !x_err;
        wr = busy && x_we && !x_err;
        if (busy && cyc == t_pulse) m_err = m_err | x_seterr;
        e_arv = rd && cyc >= t_start && cyc <= t_ahs;
        e_awv = wr && cyc >= t_start && cyc <= t_ahs;
        e_wv  = wr && cyc >= t_start && cyc <= t_whs;
        e_ip  = busy && cyc == t_pulse && x_ifu;
        e_lr  = busy && cyc == t_pulse && !x_ifu && !x_we;
        e_lb  = busy && cyc == t_pulse && x_we;
        chk("arvalid", 64'(arvalid), 64'(e_arv));
        chk("awvalid", 64'(awvalid), 64'(e_awv));
        chk("wvalid", 64'(wvalid), 64'(e_wv));
        chk("ifu_rvalid", 64'(ifu_rvalid_o), 64'(e_ip));
        chk("lsu_rvalid", 64'(lsu_rvalid_o), 64'(e_lr));
        chk("lsu_bvalid", 64'(lsu_bvalid_o), 64'(e_lb));
        chk("err", 64'(err_o), 64'(m_err));
        if (e_arv) begin
            chk("araddr", 64'(araddr), 64'(x_addr));
            chk("arsize", 64'(arsize), 64'(x_size));
        end
        if (e_awv) begin
            chk("awaddr", 64'(awaddr), 64'(x_addr));
            chk("awsize", 64'(awsize), 64'(x_size));
        end
        if (e_wv) begin
            chk("wdata", wdata, x_wdata);
            chk("wstrb", 64'(wstrb), 64'(x_wstrb));
        end
        if (e_ip || e_lr) chk("rdata", 64'(rdata_o), 64'(x_rexp));
        if (arvalid) n_arv++;
        if (ifu_rvalid_o) begin n_ip++; dut_log.push_back(0); last_rdata = rdata_o; end
        if (lsu_rvalid_o) begin n_lr++; dut_log.push_back(1); last_rdata = rdata_o; end
        if (lsu_bvalid_o) begin n_lb++; dut_log.push_back(1); end
        if (busy && cyc == t_pulse) begin
            busy = 0;
            if (!hold) begin
                if (x_ifu) ifu_pend = 0;
                else lsu_pend = 0;
            end
        end
        rst = rst_next;
        if (rst_next) begin
            busy = 0; starve = 0; m_err = 0; ifu_pend = 0; lsu_pend = 0; t_free = 0;
        end else begin
            if (gen_en) begin
                if (!ifu_pend && $urandom % 3 == 0) begin
                    ifu_pend = 1;
                    ifu_a = 32'h8000_0000 | ($urandom & 32'h0000_fffc);
                end
                if (!lsu_pend && $urandom % 3 == 0) begin
                    lsu_pend = 1;
                    lsu_w = 1'($urandom % 2);
                    r = $urandom % 3;
                    lsu_s = (r == 0) ? 4'h1 : (r == 1) ? 4'h3 : 4'hF;
                    lsu_a = 32'h8000_0000 | ($urandom & 32'h0000_ffff);
                    lsu_wd = $urandom;
                end
            end
            if (!busy && cyc >= t_free && (ifu_pend || lsu_pend)) grant();
        end
        ifu_req = ifu_pend; ifu_addr = ifu_a;
        lsu_req = lsu_pend; lsu_we = lsu_w; lsu_addr = lsu_a; lsu_strb = lsu_s; lsu_wdata = lsu_wd;
        rd = busy && !x_we && !x_err;
        wr = busy && x_we && !x_err;
        arready = rd && cyc == t_ahs;
        rvalid  = rd && cyc == t_data;
        rdata   = rvalid ? s_rdata : {$urandom, $urandom};
        rresp   = rvalid ? s_resp : 2'($urandom);
        awready = wr && cyc == t_ahs;
        wready  = wr && cyc == t_whs;
        bvalid  = wr && cyc == t_data;
        bresp   = bvalid ? s_resp : 2'($urandom);
    endtask

    task automatic run_until_idle(input int lim);
        int k = 0;
        step();
        while ((busy || ifu_pend || lsu_pend || cyc < t_free) && k < lim) begin
            step();
            k++;
        end
        n_tests++;
        if (k >= lim) begin
            n_fail++;
            $display("FAIL idle_timeout @cyc %0d: busy %0d after %0d cycles", cyc, busy, k);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0, n1, n2;
        int exp_ord[6] = '{1, 1, 0, 1, 1, 0};
        rst = 1'b1; rst_next = 1;
        ifu_req = 0; lsu_req = 0; lsu_we = 0; ifu_addr = 0; lsu_addr = 0; lsu_strb = 0; lsu_wdata = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0; awready = 0; wready = 0; bvalid = 0; bresp = 0;
        ifu_a = 0; lsu_a = 0; lsu_wd = 0; lsu_s = 0;
        repeat (2) @(posedge clk);
        step();
        rst_next = 0;
        step();

        // reset while AR is waiting for arready
        fx_en = 1; fx_da = 3; fx_dw = 0; fx_dr = 0; fx_db = 0; fx_rdata = 64'h0; fx_resp = 2'b00;
        ifu_a = 32'h8000_0010; ifu_pend = 1;
        step(); step();
        chk("pre_rst_arvalid", 64'(arvalid), 64'd1);
        rst_next = 1; step();
        rst_next = 0; step();
        chk("rst_arvalid", 64'(arvalid), 64'd0);
        chk("rst_araddr", 64'(araddr), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_rdata", 64'(rdata_o), 64'd0);
        chk("rst_wdata", wdata, 64'd0);
        run_until_idle(20);

        // IFU fetch with arready delayed 2 cycles
        fx_da = 2; fx_rdata = 64'h1122_3344_5566_7788;
        ifu_a = 32'h8000_0004; ifu_pend = 1;
        n0 = n_ip;
        step(); step();
        chk("fetch_arsize", 64'(arsize), 64'd2);
        chk("fetch_araddr0", 64'(araddr), 64'h8000_0004);
        step();
        chk("fetch_araddr1", 64'(araddr), 64'h8000_0004);
        run_until_idle(20);
        chk("fetch_pulses", 64'(n_ip - n0), 64'd1);
        chk("fetch_rdata", 64'(last_rdata), 64'h1122_3344);

        // simultaneous IFU and LSU load
        fx_da = 0; fx_rdata = 64'hCAFE_0001_BEEF_0002;
        dut_log.delete();
        n0 = n_ip; n1 = n_lr;
        ifu_a = 32'h8000_0020; ifu_pend = 1;
        lsu_a = 32'h8000_0008; lsu_s = 4'hF; lsu_w = 0; lsu_pend = 1;
        run_until_idle(30);
        chk("both_count", 64'(dut_log.size()), 64'd2);
        if (dut_log.size() == 2) begin
            chk("both_first_lsu", 64'(dut_log[0]), 64'd1);
            chk("both_second_ifu", 64'(dut_log[1]), 64'd0);
        end
        chk("both_ifu_pulses", 64'(n_ip - n0), 64'd1);
        chk("both_lsu_pulses", 64'(n_lr - n1), 64'd1);

        // byte store at offset 3, wready one cycle ahead of awready
        fx_da = 1; fx_dw = 0;
        lsu_a = 32'h8000_0003; lsu_wd = 32'h0000_00AB; lsu_s = 4'h1; lsu_w = 1; lsu_pend = 1;
        n0 = n_lb;
        step(); step();
        chk("sb_awsize", 64'(awsize), 64'd0);
        chk("sb_wstrb", 64'(wstrb), 64'h08);
        chk("sb_wdata", wdata, 64'hAB00_0000_AB00_0000);
        step();
        chk("sb_w_done", 64'(wvalid), 64'd0);
        chk("sb_aw_wait", 64'(awvalid), 64'd1);
        run_until_idle(20);
        chk("sb_bpulses", 64'(n_lb - n0), 64'd1);

        // both held continuously: starvation guard forces the IFU every third grant
        fx_da = 0; dut_log.delete(); hold = 1;
        ifu_a = 32'h8000_0100; ifu_pend = 1;
        lsu_a = 32'h8000_0200; lsu_s = 4'hF; lsu_w = 0; lsu_pend = 1;
        n2 = 0;
        while (dut_log.size() < 6 && n2 < 200) begin step(); n2++; end
        hold = 0;
        run_until_idle(40);
        chk("starve_count_ok", 64'(dut_log.size() >= 6), 64'd1);
        if (dut_log.size() >= 6)
            for (int i = 0; i < 6; i++) chk($sformatf("starve_order%0d", i), 64'(dut_log[i]), 64'(exp_ord[i]));

        // store with error response, then a misaligned half load
        fx_resp = 2'b10;
        lsu_a = 32'h8000_0010; lsu_wd = 32'h1234_5678; lsu_s = 4'hF; lsu_w = 1; lsu_pend = 1;
        n0 = n_lb;
        run_until_idle(20);
        chk("berr_pulse", 64'(n_lb - n0), 64'd1);
        chk("berr_err", 64'(err_o), 64'd1);
        fx_resp = 2'b00;
        lsu_a = 32'h8000_0003; lsu_s = 4'h3; lsu_w = 0; lsu_pend = 1;
        n0 = n_arv; n1 = n_lr; last_rdata = 32'hFFFF_FFFF;
        run_until_idle(20);
        chk("mis_no_arvalid", 64'(n_arv - n0), 64'd0);
        chk("mis_pulse", 64'(n_lr - n1), 64'd1);
        chk("mis_rdata", 64'(last_rdata), 64'd0);
        repeat (3) step();
        chk("err_sticky", 64'(err_o), 64'd1);

        // randomized traffic with occasional resets
        fx_en = 0;
        rst_next = 1; step();
        rst_next = 0;
        gen_en = 1;
        for (int i = 0; i < 4000; i++) begin
            rst_next = ($urandom % 500 == 0);
            step();
        end
        gen_en = 0; rst_next = 0;
        run_until_idle(100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ysyx_bus_scheduler.md
Name: ysyx_bus_scheduler

Overview:
Schedules one AXI4 master port (64-bit data, single-beat, one transaction outstanding) between the IFU fetch request and the LSU load/store request. Replaces ad-hoc bus steering with explicit priority, a starvation guard, 32-bit-to-64-bit lane steering, and bus-error capture. Sits between IFU/LSU and the SoC master port; the wrapper ties arlen/awlen=0, arburst/awburst=0, arid/awid=0, rready=bready=1 and wlast=wvalid.

Parameters:
ADDR_W, 32, address width; data width to requesters is fixed at 32
STARVE_MAX, 4, consecutive LSU grants allowed while IFU waits before IFU is forced (1..15)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
ifu_req  in  1  fetch request; held high until ifu_rvalid_o is seen
ifu_addr  in  ADDR_W  fetch address, 4-byte aligned
ifu_rvalid_o  out  1  one-cycle fetch response pulse
lsu_req  in  1  load/store request; held high until its response pulse
lsu_we  in  1  1=store, 0=load
lsu_addr  in  ADDR_W  byte address
lsu_strb  in  4  access mask before shifting: 0x1 byte, 0x3 half, 0xF word
lsu_wdata  in  32  store data, right-aligned
lsu_rvalid_o  out  1  one-cycle load response pulse
lsu_bvalid_o  out  1  one-cycle store-complete pulse
rdata_o  out  32  read data for the granted requester; valid with its rvalid pulse
err_o  out  1  sticky bus/alignment error flag
io_master_araddr  out  ADDR_W  read address
io_master_arsize  out  3  read size
io_master_arvalid  out  1  read address valid
io_master_arready  in  1  read address ready
io_master_rdata  in  64  read data
io_master_rresp  in  2  read response
io_master_rvalid  in  1  read data valid
io_master_awaddr  out  ADDR_W  write address
io_master_awsize  out  3  write size
io_master_awvalid  out  1  write address valid
io_master_awready  in  1  write address ready
io_master_wdata  out  64  write data
io_master_wstrb  out  8  write byte strobes
io_master_wvalid  out  1  write data valid
io_master_wready  in  1  write data ready
io_master_bresp  in  2  write response
io_master_bvalid  in  1  write response valid

Behaviour:
- States: IDLE, AR, R, AW (AW and W together), B, RESP. All outputs are registered. Reset forces IDLE, all outputs 0, starve counter 0 and err_o 0, including mid-transaction; any pending AXI response is then ignored.
- IDLE: when lsu_req=1, grant LSU unless ifu_req=1 and starve==STARVE_MAX; otherwise grant IFU if ifu_req=1. Latch requester, addr, strb, wdata and we on grant. An LSU grant while ifu_req=1 increments starve (saturating at STARVE_MAX). An IFU grant clears starve.
- Sizing: size is 0 for strb 0x1, 1 for 0x3, 2 otherwise. IFU always uses size 2. off=addr[1:0]. If (strb<<off) overflows 4 bits, no AXI transaction is issued: err_o is set and the state goes to RESP with rdata_o=0.
- AR: arvalid=1 the cycle after grant, held with araddr stable until arready; then R. R: on rvalid, capture rdata_o = addr[2] ? rdata[63:32] : rdata[31:0], unshifted. rresp!=0 sets err_o.
- AW: awvalid and wvalid rise together. Each drops independently on its own ready. wdata = {w,w}, where w = lsu_wdata<<(8*off). wstrb = (strb<<off) placed in byte lane 7:4 if addr[2], else 3:0. Go to B when both channels are accepted (same cycle or different cycles). B: on bvalid go to RESP. bresp!=0 sets err_o.
- RESP: one cycle. Pulse exactly one of ifu_rvalid_o, lsu_rvalid_o or lsu_bvalid_o. Next state is IDLE. A new grant is possible at the earliest 1 cycle after RESP.
- Latency with zero-wait slave: grant at T, arvalid at T+1, rvalid at T+2, response pulse at T+3.
- err_o clears only on rst.

Test Plan:
- Reset: assert rst mid-AR with arvalid=1 -> next cycle all outputs 0, state IDLE, err_o 0.
- IFU fetch 0x80000004, arready delayed 2 cycles, rdata=0x11223344_55667788 -> arsize=2, araddr stable while waiting, one ifu_rvalid_o pulse with rdata_o=0x11223344.
- ifu_req and lsu_req (load) rise in the same cycle -> LSU granted first, then IFU. Exactly one pulse per requester.
- Store byte: addr 0x80000003, wdata 0xAB, strb 0x1, wready 1 cycle before awready -> awsize=0, wstrb=0x08, wdata=0xAB000000AB000000, single lsu_bvalid_o pulse after bvalid.
- STARVE_MAX=2, both requests held continuously -> grant order LSU, LSU, IFU, LSU, LSU, IFU.
- bresp=2'b10 on a store -> lsu_bvalid_o still pulses, err_o=1 and stays 1. Half load at 0x80000003 -> no arvalid, err_o=1, lsu_rvalid_o pulse with rdata_o=0.
